// File: rtl/usb_rx_decoder.sv
// Full-speed USB receive bit-level decoder.
// Samples D+/D- once per bit time (bit_strobe), NRZI-decodes, detects SYNC,
// removes stuffed zeros, assembles bytes LSB-first and detects EOP.
// Ports:
//   clk, rst        : single clock, synchronous active-high reset
//   bit_strobe      : one-cycle pulse per bit time, line sampled only then
//   d_plus, d_minus : synchronized line inputs
//   rx_data         : last assembled byte (valid on rx_data_valid)
//   rx_data_valid   : pulse, new byte in rx_data
//   rx_start        : pulse, SYNC accepted
//   rx_eop          : pulse, clean EOP on a byte boundary
//   rx_active       : high from SYNC accept until EOP or error
//   rx_error        : pulse on any error
//   rx_error_code   : 1=stuff, 2=alignment, 3=line/sync; sticky until next error
`timescale 1ns/1ps
module usb_rx_decoder #(
  parameter int STUFF_LIMIT  = 6,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_strobe,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_start,
  output logic       rx_eop,
  output logic       rx_active,
  output logic       rx_error,
  output logic [1:0] rx_error_code
);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [OW-1:0] STUFF_L = OW'(STUFF_LIMIT);
  localparam logic [TW-1:0] TO_LAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, ERR_WAIT} state_t;

  state_t        state, state_n;
  logic          prev_j;
  logic [2:0]    zcnt, zcnt_n;
  logic [OW-1:0] ones, ones_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    sreg, sreg_n;
  logic [TW-1:0] jcnt, jcnt_n;
  logic          se0_seen, se0_seen_n;
  logic [7:0]    data_n;
  logic [1:0]    code_n, err_code;
  logic          start_p, valid_p, eop_p, err_p, go_err;

  logic ln_j, ln_k, ln_se0, dbit;
  assign ln_j   =  d_plus & ~d_minus;
  assign ln_k   = ~d_plus &  d_minus;
  assign ln_se0 = ~d_plus & ~d_minus;
  // NRZI: no transition is a 1; only meaningful on J/K samples
  assign dbit   = (ln_j == prev_j);

  assign rx_active = (state == DATA) || (state == EOP1) || (state == EOP2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      prev_j        <= 1'b1;
      zcnt          <= '0;
      ones          <= '0;
      bcnt          <= '0;
      sreg          <= '0;
      jcnt          <= '0;
      se0_seen      <= 1'b0;
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      rx_start      <= 1'b0;
      rx_eop        <= 1'b0;
      rx_error      <= 1'b0;
      rx_error_code <= 2'd0;
    end else begin
      state         <= state_n;
      zcnt          <= zcnt_n;
      ones          <= ones_n;
      bcnt          <= bcnt_n;
      sreg          <= sreg_n;
      jcnt          <= jcnt_n;
      se0_seen      <= se0_seen_n;
      rx_data       <= data_n;
      rx_data_valid <= valid_p;
      rx_start      <= start_p;
      rx_eop        <= eop_p;
      rx_error      <= err_p;
      rx_error_code <= code_n;
      // SE0/SE1 leave the NRZI reference untouched
      if (bit_strobe && (ln_j || ln_k)) prev_j <= ln_j;
    end
  end

  always_comb begin
    state_n    = state;
    zcnt_n     = zcnt;
    ones_n     = ones;
    bcnt_n     = bcnt;
    sreg_n     = sreg;
    jcnt_n     = jcnt;
    se0_seen_n = se0_seen;
    data_n     = rx_data;
    code_n     = rx_error_code;
    start_p    = 1'b0;
    valid_p    = 1'b0;
    eop_p      = 1'b0;
    err_p      = 1'b0;
    go_err     = 1'b0;
    err_code   = 2'd3;
    if (bit_strobe) begin
      case (state)
        IDLE: if (ln_k) begin
          state_n = SYNC;
          zcnt_n  = 3'd1;
        end
        SYNC: begin
          if (ln_j || ln_k) begin
            if (!dbit) begin
              if (zcnt == 3'd7) go_err = 1'b1;
              else zcnt_n = zcnt + 3'd1;
            end else if (zcnt == 3'd7) begin
              state_n = DATA;
              start_p = 1'b1;
              ones_n  = OW'(1);  // SYNC's closing 1 counts toward stuffing
              bcnt_n  = 3'd0;
            end else go_err = 1'b1;
          end else go_err = 1'b1;
        end
        DATA: begin
          if (ln_j || ln_k) begin
            if (ones == STUFF_L) begin
              if (dbit) begin
                go_err   = 1'b1;
                err_code = 2'd1;
              end else ones_n = '0;  // stuffed zero, dropped
            end else begin
              sreg_n = {dbit, sreg[7:1]};
              ones_n = dbit ? ones + 1'b1 : '0;
              bcnt_n = bcnt + 3'd1;
              if (bcnt == 3'd7) begin
                data_n  = sreg_n;
                valid_p = 1'b1;
              end
            end
          end else if (ln_se0) state_n = EOP1;
          else go_err = 1'b1;
        end
        EOP1: begin
          if (ln_se0) state_n = EOP2;
          else go_err = 1'b1;
        end
        EOP2: begin
          if (ln_j) begin
            state_n = IDLE;
            if (bcnt == 3'd0) eop_p = 1'b1;
            else begin
              // partial byte: flag alignment, never emit the fragment
              err_p  = 1'b1;
              code_n = 2'd2;
            end
          end else if (!ln_se0) go_err = 1'b1;
        end
        ERR_WAIT: begin
          if (ln_j) begin
            if (se0_seen || jcnt == TO_LAST) state_n = IDLE;
            else jcnt_n = jcnt + 1'b1;
          end else if (ln_se0) begin
            se0_seen_n = 1'b1;
            jcnt_n     = '0;
          end else begin
            se0_seen_n = 1'b0;
            jcnt_n     = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (go_err) begin
      state_n    = ERR_WAIT;
      err_p      = 1'b1;
      code_n     = err_code;
      jcnt_n     = '0;
      se0_seen_n = 1'b0;
    end
  end
endmodule
